// File: rtl/kbd_pkg.sv
// Shared definitions for the PIA1 keyboard-matrix writer: sizes, FSM encoding
// and the packed key-event record carried through the event FIFO.
package kbd_pkg;

   localparam int          KBD_ROWS = 10;
   localparam logic [16:0] KBD_BASE = 17'hE800;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_REQ    = 3'd1;
   localparam logic [2:0] ST_SETUP  = 3'd2;
   localparam logic [2:0] ST_STROBE = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;
   localparam logic [2:0] ST_NEXT   = 3'd5;

   typedef struct packed {
      logic       clear;
      logic       pressed;
      logic [3:0] row;
      logic [2:0] col;
   } kbd_evt_t;

endpackage

// File: rtl/kbd_event_writer_if.sv
// Event handshake from the RPi link plus the shared-bus request and the
// PIA1 cache write port. The writer uses the slave view.
interface kbd_event_writer_if;

   logic        evt_valid;
   logic        evt_ready;
   logic [3:0]  evt_row;
   logic [2:0]  evt_col;
   logic        evt_pressed;
   logic        evt_clear;
   logic        bus_req;
   logic        bus_grant;
   logic [16:0] pi_addr;
   logic [7:0]  pi_data;
   logic        pi_write_strobe;

   modport master (
      output evt_valid, evt_row, evt_col, evt_pressed, evt_clear, bus_grant,
      input  evt_ready, bus_req, pi_addr, pi_data, pi_write_strobe
   );

   modport slave (
      input  evt_valid, evt_row, evt_col, evt_pressed, evt_clear, bus_grant,
      output evt_ready, bus_req, pi_addr, pi_data, pi_write_strobe
   );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a registered full flag; a push and a pop in
// the same cycle are both honoured, even when full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             res_b,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic             do_push;
   logic             do_pop;

   assign empty      = (count == '0);
   assign do_pop     = pop && !empty;
   assign do_push    = push && (!full || do_pop);
   assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
   assign dout       = mem[rd_ptr];

   // NOTE: storage needs no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge res_b) begin
      if (!res_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == (AW+1)'(DEPTH));
      end
   end

endmodule

// File: rtl/kbd_event_writer.sv
// Turns key make/break events into bus-arbitrated write cycles that keep the
// PIA1 keyboard-matrix cache current, via a shadow copy of the matrix.
module kbd_event_writer
   import kbd_pkg::*;
#(
   parameter int          ROWS          = KBD_ROWS,
   parameter int          FIFO_DEPTH    = 4,
   parameter int          STROBE_CYCLES = 2,
   parameter logic [16:0] BASE_ADDR     = KBD_BASE
) (
   input  logic              clk,
   input  logic              res_b,
   kbd_event_writer_if.slave bus,
   output logic              busy,
   output logic              err_bad_row
);

   localparam int         EW       = $bits(kbd_evt_t);
   localparam int         SCW      = $clog2(STROBE_CYCLES) + 1;
   localparam logic [4:0] ROW_LIM  = 5'(ROWS);
   localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

   logic [2:0]     state;
   logic [3:0]     cur_row;
   logic [7:0]     cur_data;
   logic           clearing;
   logic [SCW-1:0] strobe_cnt;
   logic [7:0]     shadow [ROWS];

   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_empty;
   logic           fifo_full;
   logic [EW-1:0]  fifo_dout;
   kbd_evt_t       in_evt;
   kbd_evt_t       head;
   logic           head_bad;
   logic [7:0]     new_row;

   assign in_evt        = '{clear: bus.evt_clear, pressed: bus.evt_pressed,
                            row: bus.evt_row, col: bus.evt_col};
   assign bus.evt_ready = !fifo_full;
   assign fifo_push     = bus.evt_valid && !fifo_full;
   assign head          = kbd_evt_t'(fifo_dout);

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .res_b (res_b),
      .push  (fifo_push),
      .din   (in_evt),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      fifo_pop = (state == ST_IDLE) && !fifo_empty;
      head_bad = !head.clear && ({1'b0, head.row} >= ROW_LIM);
      new_row  = 8'hFF;
      if (!head_bad && !head.clear) begin
         new_row           = shadow[head.row];
         new_row[head.col] = !head.pressed;   // active-low: 0 = pressed
      end
   end

   always_ff @(posedge clk or negedge res_b) begin
      if (!res_b) begin
         state               <= ST_IDLE;
         cur_row             <= '0;
         cur_data            <= 8'hFF;
         clearing            <= 1'b0;
         strobe_cnt          <= '0;
         bus.bus_req         <= 1'b0;
         bus.pi_write_strobe <= 1'b0;
         bus.pi_addr         <= BASE_ADDR;
         bus.pi_data         <= 8'hFF;
         busy                <= 1'b0;
         err_bad_row         <= 1'b0;
      end else begin
         busy <= !fifo_empty || (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (fifo_pop) begin
                  if (head_bad) begin
                     err_bad_row <= 1'b1;
                  end else begin
                     clearing    <= head.clear;
                     cur_row     <= head.clear ? 4'd0 : head.row;
                     cur_data    <= new_row;
                     bus.bus_req <= 1'b1;
                     state       <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (bus.bus_grant) begin
                  bus.pi_addr <= BASE_ADDR + 17'(cur_row);
                  bus.pi_data <= cur_data;
                  state       <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               bus.pi_write_strobe <= 1'b1;
               strobe_cnt          <= '0;
               state               <= ST_STROBE;
            end
            ST_STROBE: begin
               if (strobe_cnt == SCW'(STROBE_CYCLES - 1)) begin
                  bus.pi_write_strobe <= 1'b0;
                  state               <= ST_HOLD;
               end else begin
                  strobe_cnt <= strobe_cnt + SCW'(1);
               end
            end
            ST_HOLD: state <= ST_NEXT;
            ST_NEXT: begin
               // A clear walks every row under the grant it already holds.
               if (clearing && (cur_row < LAST_ROW)) begin
                  cur_row     <= cur_row + 4'd1;
                  cur_data    <= 8'hFF;
                  bus.pi_addr <= BASE_ADDR + 17'(cur_row) + 17'd1;
                  bus.pi_data <= 8'hFF;
                  state       <= ST_SETUP;
               end else begin
                  bus.bus_req <= 1'b0;
                  clearing    <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The shadow follows the cache only once a write has actually been committed.
   always_ff @(posedge clk or negedge res_b) begin
      if (!res_b) begin
         for (int r = 0; r < ROWS; r++) shadow[r] <= 8'hFF;
      end else if (state == ST_HOLD) begin
         shadow[cur_row] <= bus.pi_data;
      end
   end

endmodule

// File: tb/tb_kbd_event_writer.sv
// Self-checking bench for kbd_event_writer: directed table, grant back-pressure,
// clear, bad-row, random traffic against a matrix model, and mid-write reset.
module tb_kbd_event_writer;

   localparam int ROWS = 10;
   localparam int SC   = 2;

   typedef struct {
      logic       clear;
      logic       pressed;
      logic [3:0] row;
      logic [2:0] col;
   } ev_t;

   typedef struct {
      logic [16:0] addr;
      logic [7:0]  data;
      int          width;
   } wr_t;

   typedef struct {
      ev_t         ev;
      logic [16:0] addr;
      logic [7:0]  data;
   } vec_t;

   logic clk   = 1'b0;
   logic res_b = 1'b0;
   logic busy;
   logic err_bad_row;

   kbd_event_writer_if kif ();

   kbd_event_writer #(
      .ROWS          (ROWS),
      .FIFO_DEPTH    (4),
      .STROBE_CYCLES (SC),
      .BASE_ADDR     (17'hE800)
   ) dut (
      .clk         (clk),
      .res_b       (res_b),
      .bus         (kif),
      .busy        (busy),
      .err_bad_row (err_bad_row)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   unstable  = 0;
   int   req_rises = 0;
   wr_t  got_q [$];
   wr_t  exp_q [$];
   int   rise_q [$];
   logic [7:0] m_shadow [ROWS];
   logic m_err;
   bit   rand_grant = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: records every strobe pulse as one committed write.
   logic        prev_strobe = 1'b0;
   logic        prev_req    = 1'b0;
   logic [16:0] lat_addr;
   logic [7:0]  lat_data;
   int          mon_width;

   always @(negedge clk) begin
      if (!res_b) begin
         prev_strobe = 1'b0;
         prev_req    = 1'b0;
      end else begin
         if (kif.pi_write_strobe) begin
            if (!prev_strobe) begin
               lat_addr  = kif.pi_addr;
               lat_data  = kif.pi_data;
               mon_width = 1;
               rise_q.push_back(cyc);
            end else begin
               mon_width++;
               if (kif.pi_addr !== lat_addr || kif.pi_data !== lat_data) unstable++;
            end
         end else if (prev_strobe) begin
            if (kif.pi_addr !== lat_addr || kif.pi_data !== lat_data) unstable++;
            got_q.push_back('{addr: lat_addr, data: lat_data, width: mon_width});
         end
         if (kif.bus_req && !prev_req) req_rises++;
         prev_strobe = kif.pi_write_strobe;
         prev_req    = kif.bus_req;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic ev_t mk(input bit clr, input bit prs, input int row, input int col);
      ev_t e;
      e.clear   = clr;
      e.pressed = prs;
      e.row     = 4'(row);
      e.col     = 3'(col);
      return e;
   endfunction

   function automatic vec_t mkv(input ev_t e, input logic [16:0] a, input logic [7:0] d);
      vec_t v;
      v.ev   = e;
      v.addr = a;
      v.data = d;
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < ROWS; r++) m_shadow[r] = 8'hFF;
      m_err = 1'b0;
      exp_q.delete();
   endtask

   // Reference: each accepted event rewrites the whole affected row(s) of the matrix.
   task automatic model_apply(input ev_t e);
      if (e.clear) begin
         for (int r = 0; r < ROWS; r++) begin
            m_shadow[r] = 8'hFF;
            exp_q.push_back('{addr: 17'hE800 + 17'(r), data: 8'hFF, width: SC});
         end
      end else if (int'(e.row) >= ROWS) begin
         m_err = 1'b1;
      end else begin
         m_shadow[e.row][e.col] = ~e.pressed;
         exp_q.push_back('{addr: 17'hE800 + 17'(e.row), data: m_shadow[e.row], width: SC});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_grant) kif.bus_grant = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input ev_t e, input int max_wait, output bit ok, output int push_cyc);
      kif.evt_valid   = 1'b1;
      kif.evt_clear   = e.clear;
      kif.evt_pressed = e.pressed;
      kif.evt_row     = e.row;
      kif.evt_col     = e.col;
      ok       = 1'b0;
      push_cyc = 0;
      for (int i = 0; i < max_wait && !ok; i++) begin
         if (kif.evt_ready) begin
            tick();
            ok       = 1'b1;
            push_cyc = cyc;
         end else begin
            tick();
         end
      end
      kif.evt_valid = 1'b0;
      if (ok) model_apply(e);
   endtask

   task automatic wait_quiet(input int n_writes, input int max_cyc, output bit done);
      done = 1'b0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         tick();
         done = (got_q.size() >= n_writes) && !busy;
      end
   endtask

   task automatic drain(input string name, input int max_cyc);
      bit  done;
      wr_t g;
      wr_t x;
      int  k = 0;
      wait_quiet(exp_q.size(), max_cyc, done);
      check({name, "_done"}, 32'(done), 1);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         x = exp_q.pop_front();
         check($sformatf("%s_addr%0d", name, k), 32'(g.addr), 32'(x.addr));
         check($sformatf("%s_data%0d", name, k), 32'(g.data), 32'(x.data));
         check($sformatf("%s_width%0d", name, k), g.width, x.width);
         k++;
      end
      check({name, "_extra_writes"}, got_q.size(), 0);
      check({name, "_missing_writes"}, exp_q.size(), 0);
      got_q.delete();
      exp_q.delete();
   endtask

   vec_t tbl [7];
   ev_t  gl_ev [6];
   ev_t  e;
   wr_t  g;
   bit   ok;
   bit   done;
   bit   seen;
   int   pc;
   int   req0;

   initial begin
      kif.evt_valid   = 1'b0;
      kif.evt_clear   = 1'b0;
      kif.evt_pressed = 1'b0;
      kif.evt_row     = '0;
      kif.evt_col     = '0;
      kif.bus_grant   = 1'b1;
      model_reset();

      // Reset state
      tick();
      tick();
      check("rst_ready", 32'(kif.evt_ready), 1);
      check("rst_bus_req", 32'(kif.bus_req), 0);
      check("rst_strobe", 32'(kif.pi_write_strobe), 0);
      check("rst_addr", 32'(kif.pi_addr), 32'h0E800);
      check("rst_data", 32'(kif.pi_data), 32'hFF);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err_bad_row), 0);
      res_b = 1'b1;
      tick();

      // Directed table, grant tied high
      tbl[0] = mkv(mk(0, 1, 3, 2), 17'hE803, 8'hFB);
      tbl[1] = mkv(mk(0, 1, 3, 0), 17'hE803, 8'hFA);
      tbl[2] = mkv(mk(0, 0, 3, 2), 17'hE803, 8'hFE);
      tbl[3] = mkv(mk(0, 1, 0, 5), 17'hE800, 8'hDF);
      tbl[4] = mkv(mk(0, 1, 0, 5), 17'hE800, 8'hDF);
      tbl[5] = mkv(mk(0, 0, 3, 0), 17'hE803, 8'hFF);
      tbl[6] = mkv(mk(0, 1, 9, 1), 17'hE809, 8'hFD);
      for (int i = 0; i < 7; i++) begin
         rise_q.delete();
         send(tbl[i].ev, 20, ok, pc);
         check($sformatf("tbl%0d_accept", i), 32'(ok), 1);
         wait_quiet(1, 40, done);
         check($sformatf("tbl%0d_done", i), 32'(done), 1);
         check($sformatf("tbl%0d_nwrites", i), got_q.size(), 1);
         if (got_q.size() > 0) begin
            g = got_q.pop_front();
            check($sformatf("tbl%0d_addr", i), 32'(g.addr), 32'(tbl[i].addr));
            check($sformatf("tbl%0d_data", i), 32'(g.data), 32'(tbl[i].data));
            check($sformatf("tbl%0d_width", i), g.width, SC);
         end
         if (i == 0 && rise_q.size() > 0) check("first_latency", rise_q[0] - pc, 3);
         check($sformatf("tbl%0d_busy", i), 32'(busy), 0);
         got_q.delete();
         exp_q.delete();
      end

      // Grant low: FSM holds one event, FIFO fills behind it
      kif.bus_grant = 1'b0;
      for (int i = 0; i < 4; i++) gl_ev[i] = mk(0, 1, 1, i);
      gl_ev[4] = mk(0, 1, 2, 0);
      gl_ev[5] = mk(0, 1, 4, 7);
      for (int i = 0; i < 5; i++) begin
         send(gl_ev[i], 10, ok, pc);
         check($sformatf("gl_accept%0d", i), 32'(ok), 1);
      end
      check("gl_ready_low", 32'(kif.evt_ready), 0);
      send(gl_ev[5], 20, ok, pc);
      check("gl_sixth_blocked", 32'(ok), 0);
      check("gl_no_strobe", got_q.size(), 0);
      check("gl_bus_req", 32'(kif.bus_req), 1);
      rise_q.delete();
      kif.bus_grant = 1'b1;
      send(gl_ev[5], 100, ok, pc);
      check("gl_sixth_accept", 32'(ok), 1);
      drain("gl", 200);
      check("gl_nrises", rise_q.size(), 6);
      for (int i = 0; i + 1 < rise_q.size(); i++)
         check($sformatf("gl_spacing%0d", i), rise_q[i+1] - rise_q[i], 5 + SC);

      // Clear after presses on rows 0 and 9
      send(mk(0, 1, 0, 0), 20, ok, pc);
      send(mk(0, 1, 9, 3), 20, ok, pc);
      drain("pre_clr", 100);
      req0 = req_rises;
      send(mk(1, 0, 0, 0), 20, ok, pc);
      check("clr_accept", 32'(ok), 1);
      check("clr_exp_rows", exp_q.size(), ROWS);
      drain("clr", 300);
      check("clr_req_pulses", req_rises - req0, 1);
      send(mk(0, 1, 9, 7), 20, ok, pc);
      wait_quiet(1, 40, done);
      if (got_q.size() > 0) check("post_clr_row9", 32'(got_q[0].data), 32'h7F);
      drain("post_clr", 40);

      // Out-of-range row is dropped and flags a sticky error
      send(mk(0, 1, 12, 0), 20, ok, pc);
      for (int i = 0; i < 15; i++) tick();
      check("bad_no_write", got_q.size(), 0);
      check("bad_err", 32'(err_bad_row), 1);
      send(mk(0, 1, 2, 2), 20, ok, pc);
      drain("after_bad", 60);
      check("bad_err_sticky", 32'(err_bad_row), 1);

      // Random traffic with a toggling grant
      rand_grant = 1'b1;
      for (int i = 0; i < 60; i++) begin
         e = mk($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 11), $urandom_range(0, 7));
         send(e, 300, ok, pc);
         check($sformatf("rnd_accept%0d", i), 32'(ok), 1);
      end
      drain("rnd", 5000);
      check("rnd_err", 32'(err_bad_row), 32'(m_err));
      rand_grant    = 1'b0;
      kif.bus_grant = 1'b1;

      // Reset during STROBE with a second event still queued
      send(mk(0, 1, 3, 6), 20, ok, pc);
      drain("pre_rst", 60);
      send(mk(0, 1, 3, 1), 20, ok, pc);
      send(mk(0, 1, 5, 0), 20, ok, pc);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (kif.pi_write_strobe) seen = 1'b1;
         else tick();
      end
      check("rst_strobe_seen", 32'(seen), 1);
      #2;
      res_b = 1'b0;
      #1;
      check("midrst_strobe", 32'(kif.pi_write_strobe), 0);
      check("midrst_bus_req", 32'(kif.bus_req), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_addr", 32'(kif.pi_addr), 32'h0E800);
      check("midrst_data", 32'(kif.pi_data), 32'hFF);
      check("midrst_err", 32'(err_bad_row), 0);
      check("midrst_ready", 32'(kif.evt_ready), 1);
      tick();
      tick();
      res_b = 1'b1;
      model_reset();
      got_q.delete();
      for (int i = 0; i < 15; i++) tick();
      check("postrst_no_write", got_q.size(), 0);
      check("postrst_busy", 32'(busy), 0);
      send(mk(0, 1, 3, 2), 20, ok, pc);
      wait_quiet(1, 40, done);
      if (got_q.size() > 0) begin
         check("postrst_addr", 32'(got_q[0].addr), 32'h0E803);
         check("postrst_data", 32'(got_q[0].data), 32'hFB);
      end
      drain("postrst", 40);

      check("addr_data_stable", unstable, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
